uart_rx_oversampled: RTL

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

---
 rtl/apb_uart_pkg.sv | 33 +++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_oversampled.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/apb_uart_pkg.sv
// Shared types and helpers for the oversampled UART receiver.
package apb_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } uart_rx_state_e;

    typedef struct packed {
        logic [3:0] data_bits;
        logic       parity_en;
        logic       parity_type;
        logic       extra_stop;
    } uart_rx_cfg_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input logic [3:0] max_bits);
        if (req < 4'd5)
            return 4'd5;
        else if (req > max_bits)
            return max_bits;
        else
            return req;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: one tick every max(div_i,1) cycles, realigned by restart_i.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 restart_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] last;

    assign last   = (div_i == '0) ? '0 : div_i - DIV_WIDTH'(1);
    // >= keeps the counter from running away if div_i shrinks mid-count
    assign tick_o = (cnt >= last);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)
            cnt <= '0;
        else if (restart_i || tick_o)
            cnt <= '0;
        else
            cnt <= cnt + DIV_WIDTH'(1);
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with 2-of-3 mid-bit voting and valid/ready output.
module uart_rx_oversampled
    import apb_uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int DIV_WIDTH     = 32
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic                     en_i,
    input  logic [DIV_WIDTH-1:0]     clk_div_i,
    input  logic [3:0]               data_bits_i,
    input  logic                     parity_en_i,
    input  logic                     parity_type_i,
    input  logic                     extra_stop_i,
    input  logic                     rx_i,
    output logic [MAX_DATA_BITS-1:0] data_o,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     data_valid_o,
    input  logic                     data_ready_i,
    output logic                     overrun_o,
    output logic                     busy_o
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] IDX_A   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] IDX_B   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] IDX_C   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] IDX_END = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    MAXB    = 4'(MAX_DATA_BITS);

    logic [1:0]               sync;
    logic                     rx_s;
    logic                     rx_prev;
    logic                     fall;
    logic                     tick;
    logic                     restart;
    uart_rx_state_e           state;
    uart_rx_cfg_t             cfg;
    logic [SW-1:0]            s_cnt;
    logic [3:0]               bit_idx;
    logic [1:0]               samp;
    logic [MAX_DATA_BITS-1:0] shreg;
    logic                     par_err;
    logic                     frm_err;
    logic                     at_mid;
    logic                     at_end;
    logic                     maj;
    logic                     fe_final;
    logic                     frame_done;

    assign rx_s     = sync[1];
    assign fall     = rx_prev & ~rx_s;
    assign restart  = (state == ST_IDLE) && fall && en_i;
    assign busy_o   = (state != ST_IDLE);
    assign at_mid   = (s_cnt == IDX_C);
    assign at_end   = (s_cnt == IDX_END);
    // third vote is the live sample at the decision tick
    assign maj      = maj3(samp[0], samp[1], rx_s);
    assign fe_final = frm_err | ~maj;
    assign frame_done = en_i && tick && at_mid &&
                        (((state == ST_STOP1) && !cfg.extra_stop) || (state == ST_STOP2));

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .div_i     (clk_div_i),
        .restart_i (restart),
        .tick_o    (tick)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], rx_i};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state        <= ST_IDLE;
            cfg          <= '0;
            s_cnt        <= '0;
            bit_idx      <= '0;
            samp         <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            data_o       <= '0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            data_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (data_valid_o && data_ready_i)
                data_valid_o <= 1'b0;

            if (!en_i) begin
                state <= ST_IDLE;
            end else if (state == ST_IDLE) begin
                if (fall) begin
                    state           <= ST_START;
                    cfg.data_bits   <= clamp_bits(data_bits_i, MAXB);
                    cfg.parity_en   <= parity_en_i;
                    cfg.parity_type <= parity_type_i;
                    cfg.extra_stop  <= extra_stop_i;
                    s_cnt           <= '0;
                    bit_idx         <= '0;
                    shreg           <= '0;
                    par_err         <= 1'b0;
                    frm_err         <= 1'b0;
                end
            end else if (tick) begin
                s_cnt <= at_end ? '0 : s_cnt + SW'(1);
                if (s_cnt == IDX_A) samp[0] <= rx_s;
                if (s_cnt == IDX_B) samp[1] <= rx_s;
                case (state)
                    ST_START: begin
                        if (at_mid && maj)
                            state <= ST_IDLE;
                        else if (at_end)
                            state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (at_mid)
                            shreg <= shreg | ({{(MAX_DATA_BITS-1){1'b0}}, maj} << bit_idx);
                        if (at_end) begin
                            if (bit_idx == cfg.data_bits - 4'd1)
                                state <= cfg.parity_en ? ST_PARITY : ST_STOP1;
                            else
                                bit_idx <= bit_idx + 4'd1;
                        end
                    end
                    ST_PARITY: begin
                        // unreceived MSBs are zero, so reducing the whole register is safe
                        if (at_mid)
                            par_err <= ((^shreg) ^ maj) != cfg.parity_type;
                        if (at_end)
                            state <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        if (at_mid) begin
                            if (cfg.extra_stop)
                                frm_err <= fe_final;
                            else
                                state <= ST_IDLE;
                        end else if (at_end) begin
                            state <= ST_STOP2;
                        end
                    end
                    ST_STOP2: begin
                        if (at_mid)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (frame_done) begin
                if (!data_valid_o || data_ready_i) begin
                    data_o       <= shreg;
                    parity_err_o <= par_err;
                    frame_err_o  <= fe_final;
                    data_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end

endmodule
